// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small FIFO; byte visible on data_out 2 cycles after the stop sample.
// Consumer backpressure via data_ready; a byte arriving while the FIFO is full is dropped and flagged.
module uart_rx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_error,
  output logic       overflow
);

  localparam int CW = $clog2(DELAY_FRAMES) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DELAY_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  logic          rx_m, rx_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push_req, push_n, ferr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      push_req    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_m        <= uart_rx;
      rx_s        <= rx_m;
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      push_req    <= push_n;
      frame_error <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            push_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // shreg stays stable through the push cycle: the next frame cannot reach DATA that soon.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [NW-1:0] count, count_next;
  logic          do_pop, do_push, full;
  logic [7:0]    head_next;

  always_comb begin
    do_pop     = data_valid & data_ready;
    full       = (count == NW'(FIFO_DEPTH));
    do_push    = push_req & (~full | do_pop);
    rd_next    = rd_ptr + PW'(do_pop);
    count_next = count + NW'(do_push) - NW'(do_pop);
    // The incoming byte becomes head only when it lands in an otherwise empty FIFO.
    head_next  = (do_push && (wr_ptr == rd_next)) ? shreg : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_next;
      count      <= count_next;
      data_valid <= (count_next != '0);
      if (count_next != '0) data_out <= head_next;
      overflow   <= push_req & full & ~do_pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at DELAY_FRAMES=16, FIFO_DEPTH=4.
module tb_uart_rx_fifo;
  localparam int DF    = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, uart_rx, data_ready;
  logic [7:0] data_out;
  logic       data_valid, frame_error, overflow;

  uart_rx_fifo #(.DELAY_FRAMES(DF), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .frame_error(frame_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         vectors = 0, miscompares = 0;
  int         ferr_cnt = 0, ovf_cnt = 0, vld_cycles = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low);
    uart_rx = 1'b0;
    repeat (DF) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DF) tick();
    end
    if (stop_low > 0) begin
      uart_rx = 1'b0;
      repeat (stop_low) tick();
    end
    uart_rx = 1'b1;
    repeat (DF) tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) tick();
    check(tag, sb.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         f0, o0, v0;
    logic [7:0] b;
    logic [7:0] burst [5];
    logic [7:0] fill  [5];
    burst = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h12};
    fill  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (frame_error) ferr_cnt++;
          if (overflow)    ovf_cnt++;
          if (data_valid)  vld_cycles++;
          if (data_valid && data_ready) begin
            if (sb.size() == 0) check("unexpected_valid", data_valid, 0);
            else                check("rx_byte", data_out, sb.pop_front());
          end
        end
      end
    join_none

    reset = 1'b1; uart_rx = 1'b1; data_ready = 1'b0;
    repeat (4) tick();
    check("rst_data_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    repeat (5) tick();

    // Single byte, consumer always ready
    data_ready = 1'b1;
    v0 = vld_cycles;
    sb.push_back(8'h41);
    send_byte(8'h41, 0);
    repeat (5) tick();
    check("a_drained", sb.size(), 0);
    check("a_valid_cycles", vld_cycles - v0, 1);
    check("a_ferr", ferr_cnt, 0);
    check("a_ovf", ovf_cnt, 0);

    // Five bytes into a four-entry FIFO with no consumer
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) sb.push_back(burst[i]);
      send_byte(burst[i], 0);
    end
    repeat (5) tick();
    check("burst_ovf_once", ovf_cnt, 1);
    check("burst_full_valid", data_valid, 1);
    check("burst_head", data_out, 8'h55);
    data_ready = 1'b1;
    drain("burst_drain");
    check("burst_empty_valid", data_valid, 0);

    // Short glitch must not start a frame
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (12 * DF) tick();
    check("glitch_valid", data_valid, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Stop bit held low, then a clean frame
    f0 = ferr_cnt;
    send_byte(8'h3C, 40);
    repeat (5) tick();
    check("ferr_once", ferr_cnt - f0, 1);
    check("ferr_fifo_empty", data_valid, 0);
    sb.push_back(8'h7E);
    send_byte(8'h7E, 0);
    drain("post_ferr_drain");
    check("post_ferr_count", ferr_cnt - f0, 1);

    // Reset in the middle of data bit 4
    data_ready = 1'b0;
    b = 8'hC3;
    uart_rx = 1'b0;
    repeat (DF) tick();
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (DF) tick();
    end
    uart_rx = b[4];
    repeat (DF / 2) tick();
    reset = 1'b1; uart_rx = 1'b1;
    repeat (3) tick();
    check("midrst_valid", data_valid, 0);
    check("midrst_data_out", data_out, 0);
    reset = 1'b0;
    tick();
    sb.push_back(8'h5A);
    send_byte(8'h5A, 0);
    repeat (5) tick();
    check("midrst_head", data_out, 8'h5A);
    data_ready = 1'b1;
    drain("midrst_drain");

    // Fill, then pop in exactly the cycle the fifth byte is pushed
    data_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(fill[i]);
      send_byte(fill[i], 0);
    end
    sb.push_back(fill[4]);
    fork
      send_byte(fill[4], 0);
      begin
        repeat (3 + DF / 2 + 9 * DF) tick();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
      end
    join
    repeat (5) tick();
    check("simul_no_ovf", ovf_cnt - o0, 0);
    check("simul_pending", sb.size(), DEPTH);
    check("simul_valid", data_valid, 1);
    check("simul_head", data_out, 8'h22);
    data_ready = 1'b1;
    drain("simul_drain");
    check("simul_empty_valid", data_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
